msx_sector_fetch: RTL and testbench

- Device-side stage of `block_device_if` (`device_mp`); sits between a floppy/disk controller core (FDC, MFRSD DSK mode) and the HPS block-device channel.
- Accepts single-sector read requests by LBA, runs the `rd`/`ack`/`buff_wr` handshake with HPS, and captures the 512-byte sector into a local buffer.
- Holds a one-entry sector cache, so a repeated request for the same LBA completes without HPS traffic.
- The controller reads captured bytes through a random-access port.

---
 rtl/msx_sector_fetch.sv | 171 +++++++++++++++++
 tb/tb_msx_sector_fetch.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/msx_sector_fetch.sv
// Single-sector fetch stage between a disk controller core and the HPS block-device channel.
// Captures one 512-byte sector per request and keeps a one-entry LBA cache for repeated reads.
module msx_sector_fetch #(
  parameter int SECTOR_AW = 9,
  parameter bit CACHE_EN  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  // controller side
  input  logic                 req,
  input  logic [31:0]          req_lba,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  input  logic [SECTOR_AW-1:0] rd_addr,
  output logic [7:0]           rd_data,
  // HPS block-device side
  output logic                 rd,
  output logic                 wr,
  input  logic                 ack,
  output logic [31:0]          lba,
  output logic [5:0]           blk_cnt,
  output logic [7:0]           buff_din,
  input  logic [7:0]           buff_dout,
  input  logic [13:0]          buff_addr,
  input  logic                 buff_wr,
  input  logic                 img_mounted,
  input  logic [63:0]          img_size
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIT,
    S_FAIL,
    S_ARM,
    S_REQ,
    S_XFER
  } state_t;

  state_t      state, state_d;
  logic        busy_d, done_d, error_d, rd_d;
  logic [31:0] lba_d;
  logic        valid, valid_d;
  logic [31:0] cached_lba, cached_lba_d;
  logic        abort, abort_d;
  logic [31:0] sec_cnt;
  logic        out_of_range;
  logic        buf_we;

  logic [7:0] buffer [2**SECTOR_AW];

  assign wr       = 1'b0;
  assign blk_cnt  = 6'd0;
  assign buff_din = 8'd0;

  // Whole sectors only; a trailing partial sector in the image is not addressable.
  assign sec_cnt      = img_size[40:9];
  assign out_of_range = (sec_cnt == 32'd0) || (req_lba >= sec_cnt);
  assign buf_we       = (state == S_XFER) && buff_wr && ack;

  logic unused_bits;
  assign unused_bits = ^{buff_addr[13:SECTOR_AW], img_size[63:41], img_size[8:0]};

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d      = state;
    busy_d       = busy;
    done_d       = 1'b0;
    error_d      = 1'b0;
    rd_d         = rd;
    lba_d        = lba;
    valid_d      = valid;
    cached_lba_d = cached_lba;
    abort_d      = abort;

    if (img_mounted) valid_d = 1'b0;

    unique case (state)
      S_IDLE: begin
        abort_d = 1'b0;
        if (req) begin
          lba_d  = req_lba;
          busy_d = 1'b1;
          if (out_of_range)
            state_d = S_FAIL;
          else if (CACHE_EN && valid && !img_mounted && (req_lba == cached_lba))
            state_d = S_HIT;
          else
            state_d = S_ARM;
        end
      end
      S_HIT: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_FAIL: begin
        error_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ARM: begin
        // A stale ack left over from a reset mid-transfer must drop before a new rd.
        if (img_mounted) begin
          rd_d    = 1'b0;
          state_d = S_FAIL;
        end else if (!ack) begin
          rd_d    = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (img_mounted) begin
          rd_d    = 1'b0;
          state_d = S_FAIL;
        end else if (ack) begin
          rd_d    = 1'b0;
          valid_d = 1'b0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (img_mounted) abort_d = 1'b1;
        if (!ack) begin
          busy_d  = 1'b0;
          abort_d = 1'b0;
          state_d = S_IDLE;
          if (abort || img_mounted) begin
            error_d = 1'b1;
          end else begin
            cached_lba_d = lba;
            valid_d      = 1'b1;
            done_d       = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      rd         <= 1'b0;
      lba        <= 32'd0;
      valid      <= 1'b0;
      cached_lba <= 32'd0;
      abort      <= 1'b0;
    end else begin
      state      <= state_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
      rd         <= rd_d;
      lba        <= lba_d;
      valid      <= valid_d;
      cached_lba <= cached_lba_d;
      abort      <= abort_d;
    end
  end

  // NOTE: the sector buffer has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (buf_we) buffer[buff_addr[SECTOR_AW-1:0]] <= buff_dout;
    rd_data <= buffer[rd_addr];
  end

endmodule

// File: tb/tb_msx_sector_fetch.sv
// Directed bench for msx_sector_fetch: miss/hit paths, range errors, remount abort,
// reset with a stale ack, and requests ignored while busy, against a small HPS model.
module tb_msx_sector_fetch;

  logic        clk;
  logic        reset;
  logic        req;
  logic [31:0] req_lba;
  logic        busy, done, error;
  logic [8:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        rd, wr;
  logic        ack;
  logic [31:0] lba;
  logic [5:0]  blk_cnt;
  logic [7:0]  buff_din;
  logic [7:0]  buff_dout;
  logic [13:0] buff_addr;
  logic        buff_wr;
  logic        img_mounted;
  logic [63:0] img_size;

  msx_sector_fetch #(.SECTOR_AW(9), .CACHE_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req(req), .req_lba(req_lba),
    .busy(busy), .done(done), .error(error),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .rd(rd), .wr(wr), .ack(ack), .lba(lba), .blk_cnt(blk_cnt),
    .buff_din(buff_din), .buff_dout(buff_dout), .buff_addr(buff_addr),
    .buff_wr(buff_wr), .img_mounted(img_mounted), .img_size(img_size)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Event monitor, sampled on the falling edge.
  int          rd_rises = 0;
  int          done_cnt = 0;
  int          err_cnt  = 0;
  logic        rd_q     = 1'b0;
  logic [31:0] rd_lba   = 32'd0;

  always @(negedge clk) begin
    if (rd && !rd_q) rd_rises++;
    if (rd) rd_lba = lba;
    rd_q = rd;
    if (done) done_cnt++;
    if (error) err_cnt++;
  end

  // HPS model: ack ~3 cycles after rd, 512 bytes of addr^0x5A, then ack drops.
  int mount_at = -1;
  int stall_at = -1;
  int hps_byte = -1;

  initial begin
    ack = 1'b0; buff_wr = 1'b0; buff_dout = 8'd0; buff_addr = 14'd0; img_mounted = 1'b0;
    forever begin
      @(negedge clk);
      if (rd && !ack) begin
        repeat (2) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 512; i++) begin
          hps_byte = i;
          if (i == stall_at) begin
            buff_wr = 1'b0;
            repeat (10) @(negedge clk);
            break;
          end
          buff_wr     = 1'b1;
          buff_addr   = i[13:0];
          buff_dout   = i[7:0] ^ 8'h5A;
          img_mounted = (i == mount_at);
          @(negedge clk);
          img_mounted = 1'b0;
        end
        buff_wr = 1'b0;
        repeat (2) @(negedge clk);
        ack      = 1'b0;
        hps_byte = -1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic do_req(input logic [31:0] l);
    @(negedge clk);
    req = 1'b1; req_lba = l;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_end(input int budget, output int cyc, output logic [1:0] res);
    cyc = 1;
    while (cyc <= budget && !done && !error) begin
      @(negedge clk);
      cyc++;
    end
    res = {done, error};
    @(negedge clk);
  endtask

  task automatic read_byte(input logic [8:0] a, output logic [7:0] d);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    d = rd_data;
  endtask

  int          cyc;
  logic [1:0]  res;
  logic [7:0]  d;
  int          r0, d0, e0;
  int          rd_bad;
  int          waited;

  initial begin
    reset = 1'b1; req = 1'b0; req_lba = 32'd0; rd_addr = 9'd0;
    img_size = 64'd737280;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_error", {31'd0, error}, 32'd0);
    check("reset_rd", {31'd0, rd}, 32'd0);
    check("reset_lba", lba, 32'd0);
    check("tied_outs", {wr, blk_cnt, buff_din}, 32'd0);

    // Miss on LBA 5
    r0 = rd_rises; d0 = done_cnt; e0 = err_cnt;
    do_req(32'd5);
    check("miss5_busy", {31'd0, busy}, 32'd1);
    wait_end(2000, cyc, res);
    check("miss5_end", {30'd0, res}, 32'd2);
    check("miss5_rd_count", rd_rises - r0, 32'd1);
    check("miss5_rd_lba", rd_lba, 32'd5);
    check("miss5_done_count", done_cnt - d0, 32'd1);
    check("miss5_err_count", err_cnt - e0, 32'd0);
    read_byte(9'h1FF, d);
    check("data_1ff", {24'd0, d}, 32'hA5);
    read_byte(9'h000, d);
    check("data_000", {24'd0, d}, 32'h5A);
    read_byte(9'h0C3, d);
    check("data_0c3", {24'd0, d}, 32'h99);

    // Hit on LBA 5
    r0 = rd_rises;
    do_req(32'd5);
    wait_end(20, cyc, res);
    check("hit5_end", {30'd0, res}, 32'd2);
    check("hit5_latency", cyc, 32'd2);
    check("hit5_no_rd", rd_rises - r0, 32'd0);

    // Miss on LBA 6
    r0 = rd_rises;
    do_req(32'd6);
    wait_end(2000, cyc, res);
    check("miss6_end", {30'd0, res}, 32'd2);
    check("miss6_rd_count", rd_rises - r0, 32'd1);
    check("miss6_rd_lba", rd_lba, 32'd6);

    // One past the last sector
    r0 = rd_rises;
    do_req(32'd1440);
    wait_end(20, cyc, res);
    check("oor1440_end", {30'd0, res}, 32'd1);
    check("oor1440_no_rd", rd_rises - r0, 32'd0);

    // Cache survives the failed request
    do_req(32'd6);
    wait_end(20, cyc, res);
    check("hit6_after_fail", {30'd0, res}, 32'd2);
    check("hit6_latency", cyc, 32'd2);
    check("hit6_no_rd", rd_rises - r0, 32'd0);

    // Last valid sector
    do_req(32'd1439);
    wait_end(2000, cyc, res);
    check("last1439_end", {30'd0, res}, 32'd2);
    check("last1439_rd_lba", rd_lba, 32'd1439);

    // Empty image
    img_size = 64'd0;
    r0 = rd_rises;
    do_req(32'd0);
    wait_end(20, cyc, res);
    check("empty_end", {30'd0, res}, 32'd1);
    check("empty_no_rd", rd_rises - r0, 32'd0);
    img_size = 64'd737280;

    // Remount during transfer
    mount_at = 100;
    r0 = rd_rises; d0 = done_cnt; e0 = err_cnt;
    do_req(32'd9);
    wait_end(2000, cyc, res);
    check("mount_end", {30'd0, res}, 32'd1);
    check("mount_no_done", done_cnt - d0, 32'd0);
    check("mount_ack_low", {31'd0, ack}, 32'd0);
    mount_at = -1;
    do_req(32'd9);
    wait_end(2000, cyc, res);
    check("after_mount_end", {30'd0, res}, 32'd2);
    check("after_mount_rd_count", rd_rises - r0, 32'd2);

    // Reset mid-transfer with ack held high
    stall_at = 50;
    do_req(32'd11);
    waited = 0;
    while (hps_byte != 50 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("stall_reached", hps_byte, 32'd50);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    stall_at = -1;
    r0 = rd_rises; d0 = done_cnt;
    do_req(32'd11);
    check("stale_ack_high", {31'd0, ack}, 32'd1);
    rd_bad = 0;
    waited = 0;
    while (ack && waited < 100) begin
      if (rd) rd_bad++;
      @(negedge clk);
      waited++;
    end
    check("stale_ack_rd_low", rd_bad, 32'd0);
    wait_end(2000, cyc, res);
    check("post_reset_end", {30'd0, res}, 32'd2);
    check("post_reset_rd_count", rd_rises - r0, 32'd1);
    check("post_reset_rd_lba", rd_lba, 32'd11);
    check("post_reset_done_count", done_cnt - d0, 32'd1);

    // Request while busy is dropped
    r0 = rd_rises; d0 = done_cnt;
    do_req(32'd7);
    repeat (2) @(negedge clk);
    check("ignore_busy_high", {31'd0, busy}, 32'd1);
    req = 1'b1; req_lba = 32'd8;
    @(negedge clk);
    req = 1'b0;
    wait_end(2000, cyc, res);
    check("ignore_end", {30'd0, res}, 32'd2);
    repeat (30) @(negedge clk);
    check("ignore_done_count", done_cnt - d0, 32'd1);
    check("ignore_rd_count", rd_rises - r0, 32'd1);
    check("ignore_rd_lba", rd_lba, 32'd7);
    check("ignore_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
